// File: rtl/cache_mem_arbiter_if.sv
// Bus bundle between the I/D cache pair, main memory and the shared-memory arbiter.
// The arbiter attaches through the slave modport; the cache/memory side through master.
interface cache_mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              i_miss;
    logic [ADDR_W-1:0] i_miss_addr;
    logic              d_miss;
    logic [ADDR_W-1:0] d_miss_addr;
    logic              st_req;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;
    logic              st_ack;

    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_wr;
    logic [DATA_W-1:0] mem_data_rd;
    logic              mem_data_valid;

    logic [ADDR_W-1:0] fill_addr;
    logic [DATA_W-1:0] fill_data;
    logic              i_data_we;
    logic              d_data_we;
    logic              i_tag_we;
    logic              d_tag_we;
    logic              i_busy;
    logic              d_busy;

    modport slave (
        input  i_miss, i_miss_addr, d_miss, d_miss_addr,
        input  st_req, st_addr, st_data,
        input  mem_data_rd, mem_data_valid,
        output st_ack, mem_en, mem_wr, mem_addr, mem_data_wr,
        output fill_addr, fill_data, i_data_we, d_data_we,
        output i_tag_we, d_tag_we, i_busy, d_busy
    );

    modport master (
        output i_miss, i_miss_addr, d_miss, d_miss_addr,
        output st_req, st_addr, st_data,
        output mem_data_rd, mem_data_valid,
        input  st_ack, mem_en, mem_wr, mem_addr, mem_data_wr,
        input  fill_addr, fill_data, i_data_we, d_data_we,
        input  i_tag_we, d_tag_we, i_busy, d_busy
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Serialises write-through stores and I/D block fills onto one memory port.
// A fill issues 8 back-to-back word reads, then streams returned words into the owning cache.
module cache_mem_arbiter (
    input logic               clk,
    input logic               rst_n,
    cache_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL_D = 2'd1,
        FILL_I = 2'd2
    } state_t;

    state_t      state;
    logic [15:0] base;
    logic [2:0]  issue_cnt;
    logic [2:0]  recv_cnt;
    logic        issue_done;

    logic        grant_st;
    logic        grant_d;
    logic        grant_i;
    logic        filling;
    logic        issuing;
    logic        receiving;
    logic        recv_last;
    logic [15:0] issue_addr;
    logic [15:0] recv_addr;

    // Fixed priority in IDLE; the store grant is gated by reset so outputs stay quiet in reset.
    always_comb begin
        grant_st = 1'b0;
        grant_d  = 1'b0;
        grant_i  = 1'b0;
        if (rst_n && state == IDLE) begin
            if (bus.st_req)      grant_st = 1'b1;
            else if (bus.d_miss) grant_d  = 1'b1;
            else if (bus.i_miss) grant_i  = 1'b1;
        end
    end

    assign filling    = (state == FILL_D) || (state == FILL_I);
    assign issuing    = filling && !issue_done;
    assign receiving  = filling && bus.mem_data_valid;
    assign recv_last  = receiving && (recv_cnt == 3'd7);
    assign issue_addr = base + {12'd0, issue_cnt, 1'b0};
    assign recv_addr  = base + {12'd0, recv_cnt, 1'b0};

    always_comb begin
        bus.st_ack      = grant_st;
        bus.mem_en      = grant_st || issuing;
        bus.mem_wr      = grant_st;
        bus.mem_addr    = '0;
        bus.mem_data_wr = '0;
        if (grant_st) begin
            bus.mem_addr    = bus.st_addr;
            bus.mem_data_wr = bus.st_data;
        end else if (issuing) begin
            bus.mem_addr = issue_addr;
        end

        bus.fill_addr = receiving ? recv_addr : '0;
        bus.fill_data = receiving ? bus.mem_data_rd : '0;
        bus.i_data_we = receiving && (state == FILL_I);
        bus.d_data_we = receiving && (state == FILL_D);
        bus.i_tag_we  = recv_last && (state == FILL_I);
        bus.d_tag_we  = recv_last && (state == FILL_D);
        bus.i_busy    = (state == FILL_I);
        bus.d_busy    = (state == FILL_D);
    end

    // Issue and receive run independently: reads keep issuing while early words return.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            base       <= '0;
            issue_cnt  <= '0;
            recv_cnt   <= '0;
            issue_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d || grant_i) begin
                        base       <= (grant_d ? bus.d_miss_addr : bus.i_miss_addr) & 16'hFFF0;
                        issue_cnt  <= '0;
                        recv_cnt   <= '0;
                        issue_done <= 1'b0;
                        state      <= grant_d ? FILL_D : FILL_I;
                    end
                end
                FILL_D, FILL_I: begin
                    if (issuing) begin
                        issue_cnt <= issue_cnt + 3'd1;
                        if (issue_cnt == 3'd7) issue_done <= 1'b1;
                    end
                    if (receiving) recv_cnt <= recv_cnt + 3'd1;
                    if (recv_last) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: latency-accurate memory model plus a transaction-level
// schedule model that predicts every grant, read, fill write, tag write and busy cycle.
module tb_cache_mem_arbiter;
    localparam int MEM_LAT = 4;

    localparam logic [7:0] E_ACK  = 8'd1;
    localparam logic [7:0] E_WR   = 8'd2;
    localparam logic [7:0] E_RD   = 8'd3;
    localparam logic [7:0] E_IWE  = 8'd4;
    localparam logic [7:0] E_DWE  = 8'd5;
    localparam logic [7:0] E_ITAG = 8'd6;
    localparam logic [7:0] E_DTAG = 8'd7;
    localparam logic [7:0] E_IBSY = 8'd8;
    localparam logic [7:0] E_DBSY = 8'd9;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_cmp;
    int   n_fail;

    cache_mem_arbiter_if bus ();

    cache_mem_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory: word array, MEM_LAT-deep read return pipe, shares the arbiter reset.
    logic [15:0]        mem [0:32767];
    logic [MEM_LAT-1:0] pv;
    logic [15:0]        pa [MEM_LAT];
    logic               spur;
    logic [15:0]        spur_data;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv <= '0;
        end else begin
            pv    <= {pv[MEM_LAT-2:0], bus.mem_en && !bus.mem_wr};
            pa[0] <= bus.mem_addr;
            for (int k = 1; k < MEM_LAT; k++) pa[k] <= pa[k-1];
            if (bus.mem_en && bus.mem_wr) mem[bus.mem_addr[15:1]] <= bus.mem_data_wr;
        end
    end

    assign bus.mem_data_valid = pv[MEM_LAT-1] | spur;
    assign bus.mem_data_rd    = pv[MEM_LAT-1] ? mem[pa[MEM_LAT-1][15:1]] : spur_data;

    // Event log: {cycle, kind, addr, data}
    logic [71:0] act_q[$];
    logic [71:0] exp_q[$];

    function automatic logic [71:0] ev(int c, logic [7:0] kind, logic [15:0] a, logic [15:0] d);
        return {32'(c), kind, a, d};
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.st_ack)                act_q.push_back(ev(cyc, E_ACK, 16'h0, 16'h0));
            if (bus.mem_en && bus.mem_wr)  act_q.push_back(ev(cyc, E_WR, bus.mem_addr, bus.mem_data_wr));
            if (bus.mem_en && !bus.mem_wr) act_q.push_back(ev(cyc, E_RD, bus.mem_addr, 16'h0));
            if (bus.i_data_we)             act_q.push_back(ev(cyc, E_IWE, bus.fill_addr, bus.fill_data));
            if (bus.d_data_we)             act_q.push_back(ev(cyc, E_DWE, bus.fill_addr, bus.fill_data));
            if (bus.i_tag_we)              act_q.push_back(ev(cyc, E_ITAG, 16'h0, 16'h0));
            if (bus.d_tag_we)              act_q.push_back(ev(cyc, E_DTAG, 16'h0, 16'h0));
            if (bus.i_busy)                act_q.push_back(ev(cyc, E_IBSY, 16'h0, 16'h0));
            if (bus.d_busy)                act_q.push_back(ev(cyc, E_DBSY, 16'h0, 16'h0));
        end
    end

    function automatic logic [127:0] outs();
        return 128'({bus.st_ack, bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_data_wr,
                     bus.fill_addr, bus.fill_data, bus.i_data_we, bus.d_data_we,
                     bus.i_tag_we, bus.d_tag_we, bus.i_busy, bus.d_busy});
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // A fill granted in cycle g: reads g+1..g+8, words g+1+L..g+8+L, tag on the last word.
    function automatic void exp_fill(int g, bit is_d, logic [15:0] a);
        logic [15:0] b;
        logic [15:0] wa;
        b = a & 16'hFFF0;
        for (int k = 0; k < 8; k++) begin
            wa = b + 16'(2 * k);
            exp_q.push_back(ev(g + 1 + k, E_RD, wa, 16'h0));
            exp_q.push_back(ev(g + 1 + k + MEM_LAT, is_d ? E_DWE : E_IWE, wa, mem[wa[15:1]]));
        end
        for (int t = g + 1; t <= g + 8 + MEM_LAT; t++)
            exp_q.push_back(ev(t, is_d ? E_DBSY : E_IBSY, 16'h0, 16'h0));
        exp_q.push_back(ev(g + 8 + MEM_LAT, is_d ? E_DTAG : E_ITAG, 16'h0, 16'h0));
    endfunction

    task automatic compare_events(input string name);
        int n;
        act_q.sort();
        exp_q.sort();
        chk({name, ".count"}, 128'(act_q.size()), 128'(exp_q.size()));
        n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int k = 0; k < n; k++)
            chk($sformatf("%s.ev%0d", name, k), 128'(act_q[k]), 128'(exp_q[k]));
    endtask

    // Arrival cycles relative to the call (-1 = absent). Requests are held until served;
    // with drop set, a miss line falls at a random point inside its own fill.
    task automatic run_txn(input string name,
                           input int st_t, input logic [15:0] sa, input logic [15:0] sd,
                           input int d_t, input logic [15:0] da,
                           input int i_t, input logic [15:0] ia, input bit drop);
        int  c0, free, st_g, d_g, i_g, d_end, i_end, horizon;
        bit  st_p, d_p, i_p;
        c0 = cyc;
        act_q.delete();
        exp_q.delete();
        st_g = -1; d_g = -1; i_g = -1;
        st_p = (st_t >= 0); d_p = (d_t >= 0); i_p = (i_t >= 0);
        free = 0;
        for (int t = 0; t < 200 && (st_p || d_p || i_p); t++) begin
            if (t >= free) begin
                if (st_p && t >= st_t) begin
                    st_g = t; st_p = 1'b0; free = t + 1;
                end else if (d_p && t >= d_t) begin
                    d_g = t; d_p = 1'b0; free = t + 9 + MEM_LAT;
                end else if (i_p && t >= i_t) begin
                    i_g = t; i_p = 1'b0; free = t + 9 + MEM_LAT;
                end
            end
        end
        if (st_g >= 0) begin
            exp_q.push_back(ev(c0 + st_g, E_ACK, 16'h0, 16'h0));
            exp_q.push_back(ev(c0 + st_g, E_WR, sa, sd));
        end
        if (d_g >= 0) exp_fill(c0 + d_g, 1'b1, da);
        if (i_g >= 0) exp_fill(c0 + i_g, 1'b0, ia);
        d_end = (d_g < 0) ? -1 : d_g + (drop ? int'($urandom_range(0, 8 + MEM_LAT)) : 8 + MEM_LAT);
        i_end = (i_g < 0) ? -1 : i_g + (drop ? int'($urandom_range(0, 8 + MEM_LAT)) : 8 + MEM_LAT);
        horizon = free + 2;
        bus.st_addr     = sa;
        bus.st_data     = sd;
        bus.d_miss_addr = da;
        bus.i_miss_addr = ia;
        for (int t = 0; t <= horizon; t++) begin
            bus.st_req = (st_g >= 0) && (t >= st_t) && (t <= st_g);
            bus.d_miss = (d_g >= 0) && (t >= d_t) && (t <= d_end);
            bus.i_miss = (i_g >= 0) && (t >= i_t) && (t <= i_end);
            tick();
        end
        bus.st_req = 1'b0;
        bus.d_miss = 1'b0;
        bus.i_miss = 1'b0;
        compare_events(name);
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        for (int k = 0; k < 32768; k++) mem[k] = 16'($urandom);
        spur            = 1'b0;
        spur_data       = 16'h0;
        bus.i_miss      = 1'b0;
        bus.i_miss_addr = 16'h0;
        bus.d_miss      = 1'b1;
        bus.d_miss_addr = 16'h1234;
        bus.st_req      = 1'b1;
        bus.st_addr     = 16'h4444;
        bus.st_data     = 16'h5555;
        rst_n           = 1'b0;

        // Reset with requests pending: everything silent
        tick();
        chk("reset.outs", outs(), 128'h0);
        tick();
        chk("reset.outs2", outs(), 128'h0);
        bus.st_req = 1'b0;
        bus.d_miss = 1'b0;
        rst_n      = 1'b1;
        tick();
        chk("idle.outs", outs(), 128'h0);

        run_txn("i_fill_0026", -1, 16'h0, 16'h0, -1, 16'h0, 0, 16'h0026, 1'b0);
        run_txn("d_and_i", -1, 16'h0, 16'h0, 0, 16'h8008, 0, 16'h0100, 1'b0);
        run_txn("st_during_d", 3, 16'h4002, 16'hBEEF, 0, 16'h9A30, -1, 16'h0, 1'b0);
        run_txn("st_and_d", 0, 16'h4100, 16'h1357, 0, 16'hC04E, -1, 16'h0, 1'b0);
        run_txn("d_drop_mid", -1, 16'h0, 16'h0, 0, 16'hFFF6, -1, 16'h0, 1'b1);

        // Spurious valid in IDLE, then a fill must still produce exactly 8 words
        act_q.delete();
        spur      = 1'b1;
        spur_data = 16'hA5A5;
        tick();
        spur = 1'b0;
        tick();
        chk("spurious.events", 128'(act_q.size()), 128'h0);
        run_txn("after_spurious", -1, 16'h0, 16'h0, 0, 16'hB010, -1, 16'h0, 1'b0);

        // Asynchronous reset in cycle 5 of an I fill
        bus.i_miss      = 1'b1;
        bus.i_miss_addr = 16'h0240;
        for (int k = 0; k < 5; k++) tick();
        chk("pre_reset.i_busy", 128'(bus.i_busy), 128'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_reset.outs", outs(), 128'h0);
        bus.i_miss = 1'b0;
        tick();
        tick();
        chk("mid_reset.outs2", outs(), 128'h0);
        rst_n = 1'b1;
        tick();
        chk("post_reset.outs", outs(), 128'h0);
        run_txn("d_after_reset", -1, 16'h0, 16'h0, 0, 16'h8810, -1, 16'h0, 1'b0);

        // Randomised mixes of arrivals, addresses, data and early line drops
        for (int it = 0; it < 24; it++) begin
            int          st_t, d_t, i_t;
            logic [15:0] sa, sd, da, ia;
            st_t = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 14));
            d_t  = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 6));
            i_t  = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 6));
            if (st_t < 0 && d_t < 0 && i_t < 0) i_t = 0;
            sa = 16'h4000 | (16'($urandom) & 16'h3FFE);
            sd = 16'($urandom);
            da = 16'h8000 | (16'($urandom) & 16'h7FFF);
            ia = 16'($urandom) & 16'h3FFF;
            run_txn($sformatf("rand%0d", it), st_t, sa, sd, d_t, da, i_t, ia,
                    1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Shared-memory arbiter between the I-cache/D-cache pair and the multi-cycle main memory. It accepts instruction-miss fills, data-miss fills and write-through stores, and serialises them onto the single memory port. For a fill it issues the 8 word reads of the 16-byte block back to back. It then streams the returned words into the owning cache's data array and pulses the tag write on the last word.

## Interface
- MEM_LAT, 4: memory read latency in cycles. A read issued in cycle t returns `mem_data_valid` in cycle t+MEM_LAT.
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- i_miss  in  1  I-cache miss, held until the fill completes
- i_miss_addr  in  16  instruction byte address of the miss
- d_miss  in  1  D-cache miss, held until the fill completes
- d_miss_addr  in  16  data byte address of the miss
- st_req  in  1  write-through store request, held until `st_ack`
- st_addr  in  16  store byte address
- st_data  in  16  store data
- st_ack  out  1  store issued to memory this cycle
- mem_en  out  1  memory enable
- mem_wr  out  1  memory write (1) / read (0)
- mem_addr  out  16  memory byte address
- mem_data_wr  out  16  memory write data
- mem_data_rd  in  16  memory read data
- mem_data_valid  in  1  `mem_data_rd` valid this cycle
- fill_addr  out  16  byte address of the word being filled
- fill_data  out  16  word being filled (equals `mem_data_rd`)
- i_data_we, d_data_we  out  1  data-array write strobe for the I-cache or D-cache
- i_tag_we, d_tag_we  out  1  tag-array write strobe, asserted on the last word only
- i_busy, d_busy  out  1  fill in progress for I or D

## Operation
- States: IDLE, FILL_D, FILL_I, held in a 2-bit register.
- Arbitration in IDLE, fixed priority: `st_req` first, then `d_miss`, then `i_miss`.
- Store, granted in IDLE when `st_req`=1:
  - Same cycle, combinational: `mem_en`=1, `mem_wr`=1, `mem_addr`=`st_addr`, `mem_data_wr`=`st_data`, `st_ack`=1.
  - State stays IDLE. A miss pending in the same cycle is taken on the next cycle.
- Fill start, granted in IDLE with no `st_req`:
  - Register base = miss_addr & 16'hFFF0 and the owner (I or D).
  - Clear the issue counter and the receive counter (3 bits each).
  - Go to FILL_D or FILL_I.
- Issue phase, in FILL_x while issue_cnt < 8:
  - `mem_en`=1, `mem_wr`=0, `mem_addr` = base + 2·issue_cnt.
  - issue_cnt increments once per cycle; a saturating done flag marks all 8 issued.
- Receive phase, on each `mem_data_valid` in FILL_x:
  - `fill_addr` = base + 2·recv_cnt, `fill_data` = `mem_data_rd`, owner's `*_data_we`=1.
  - recv_cnt increments.
- On the 8th valid: owner's `*_tag_we`=1 in the same cycle, and state returns to IDLE on the next edge.
- `i_busy` = (state==FILL_I); `d_busy` = (state==FILL_D).
- Stores are not granted during a fill: `st_ack` stays 0 and the MEM stage stays stalled.
- A miss line dropping mid-fill does not abort the fill; all 8 words and the tag are still written.
- `mem_data_valid` in IDLE is ignored; no strobes are asserted.
- Arithmetic: addresses are modulo 2^16, so base + 14 never carries out of the block.

## Timing
- Reset (async, any state): state=IDLE, counters=0, base=0. All outputs are 0, including `mem_en`, `st_ack` and every `*_we`/`*_busy`. The memory shares this reset, so in-flight reads are discarded.
- Store: zero-cycle grant; `st_ack` is asserted in the cycle `st_req` is seen in IDLE.
- Fill cycle numbering, with the miss seen in IDLE in cycle 0:
  - Reads are issued in cycles 1–8.
  - Valids arrive in cycles 1+MEM_LAT through 8+MEM_LAT.
  - The tag write occurs in cycle 8+MEM_LAT.
  - IDLE is reached in cycle 9+MEM_LAT.
- With the default MEM_LAT: 12-cycle fill, next grant possible in cycle 13.
- `*_busy` is high from cycle 1 through the tag-write cycle inclusive.
- `i_miss` and `d_miss` rising together: D is served first. I is granted in the first IDLE cycle after the D fill, unless `st_req` is pending.
- `st_req` and `d_miss` together in cycle 0: store in cycle 0, D fill granted in cycle 1.

## Test plan
- Reset mid-fill: assert rst_n=0 during cycle 5 of an I fill → all outputs 0 immediately, state IDLE. A new `d_miss` after release completes normally with exactly 8 `d_data_we`.
- I miss at 16'h0026 → reads to 0x0020, 0x0022 … 0x002E in cycles 1–8. `i_data_we` in cycles 5–12 with the matching `fill_addr`. `i_tag_we` only in cycle 12; `d_*` strobes never asserted.
- `i_miss`(0x0100) and `d_miss`(0x8008) in the same cycle → D fill of 0x8000–0x800E completes first (`d_tag_we` in cycle 12). I fill reads start in cycle 14.
- `st_req`(0x4002, 16'hBEEF) during a D fill → `st_ack`=0 until the IDLE cycle after `d_tag_we`. Then a one-cycle write with `mem_wr`=1, addr 0x4002, data 16'hBEEF.
- `st_req` and `d_miss` in the same cycle → `st_ack` in cycle 0, first fill read in cycle 2, `d_tag_we` in cycle 13.
- Spurious `mem_data_valid` pulse in IDLE → no `*_data_we` or `*_tag_we`, and the counters are unchanged (checked by a following fill producing exactly 8 writes).
